// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant is held for a whole packet or up to MAX_BURST beats, whichever ends first.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         fifo_we_o,
    output logic [DATA_W-1:0]            fifo_data_o,
    input  logic                         fifo_full_i,
    output logic                         grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ID_W-1:0]   pick_id;
    logic              pick_found;
    logic              accept;
    logic              burst_done;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Descending scan so the closest valid requester after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_add(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_id    = wrap_add(rr_ptr, k);
            end
        end
    end

    // Reset masks the write path so nothing reaches the FIFO in the reset cycle.
    assign accept     = (state == BUSY) && !rst && !fifo_full_i && req_valid_i[grant_id];
    assign burst_done = req_last_i[grant_id] || (beat_cnt == LAST_BEAT);

    assign fifo_we_o     = accept;
    assign fifo_data_o   = accept ? req_data_i[int'(grant_id)*DATA_W +: DATA_W] : '0;
    assign req_ready_o   = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign grant_valid_o = (state == BUSY);
    assign grant_id_o    = grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (burst_done) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=32, MAX_BURST=8).
module tb_fifo_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   valid;
    logic [3:0]   last;
    logic [31:0]  rd [4];
    logic [127:0] data_bus;
    logic [3:0]   ready;
    logic         we;
    logic [31:0]  fdata;
    logic         full;
    logic         gv;
    logic [1:0]   gid;

    int n_vec;
    int n_err;
    int wr_cnt;
    int base_cnt;

    assign data_bus = {rd[3], rd[2], rd[1], rd[0]};

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (valid),
        .req_data_i    (data_bus),
        .req_last_i    (last),
        .req_ready_o   (ready),
        .fifo_we_o     (we),
        .fifo_data_o   (fdata),
        .fifo_full_i   (full),
        .grant_valid_o (gv),
        .grant_id_o    (gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Invariants checked every cycle, mid-period.
    always @(negedge clk) begin
        if (we === 1'b1) wr_cnt++;
        chk("no_we_while_full", {31'd0, we & full}, 32'd0);
        chk("ready_onehot", {31'd0, $countones(ready) <= 1}, 32'd1);
    end

    // Drive one cycle of inputs, check all outputs, then advance past the edge.
    task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [3:0] e_rdy, input logic [31:0] e_data,
                       input logic e_gv, input logic [1:0] e_gid);
        valid = v;
        last  = l;
        full  = f;
        #1;
        chk({tag, "/ready"}, {28'd0, ready}, {28'd0, e_rdy});
        chk({tag, "/we"},    {31'd0, we},    {31'd0, (e_rdy != 4'd0)});
        chk({tag, "/data"},  fdata,          e_data);
        chk({tag, "/gv"},    {31'd0, gv},    {31'd0, e_gv});
        chk({tag, "/gid"},   {30'd0, gid},   {30'd0, e_gid});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 2'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; wr_cnt = 0; base_cnt = 0;
        rst = 1'b1; valid = '0; last = '0; full = 1'b0;
        for (int i = 0; i < 4; i++) rd[i] = '0;
        do_reset();

        // Single requester 2, 3-beat packet
        rd[2] = 32'hA0;
        cyc("t1_idle", 4'b0100, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd0);
        cyc("t1_b0",   4'b0100, 4'b0000, 1'b0, 4'b0100, 32'hA0, 1'b1, 2'd2);
        rd[2] = 32'hA1;
        cyc("t1_b1",   4'b0100, 4'b0000, 1'b0, 4'b0100, 32'hA1, 1'b1, 2'd2);
        rd[2] = 32'hA2;
        cyc("t1_b2",   4'b0100, 4'b0100, 1'b0, 4'b0100, 32'hA2, 1'b1, 2'd2);
        cyc("t1_done", 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd2);
        // rr_ptr should now be 3: with 0 and 3 valid, 3 wins
        rd[0] = 32'h00; rd[3] = 32'h30;
        cyc("t1_rr_idle", 4'b1001, 4'b1001, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd2);
        cyc("t1_rr_g3",   4'b1001, 4'b1001, 1'b0, 4'b1000, 32'h30, 1'b1, 2'd3);
        cyc("t1_rr_idl2", 4'b0001, 4'b0001, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd3);
        cyc("t1_rr_g0",   4'b0001, 4'b0001, 1'b0, 4'b0001, 32'h00, 1'b1, 2'd0);
        cyc("t1_end",     4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd0);

        // All four valid, 1-beat packets: order 0,1,2,3,0 after reset
        do_reset();
        for (int i = 0; i < 4; i++) rd[i] = 32'hB0 + i;
        begin
            logic [1:0] prev;
            prev = 2'd0;
            for (int k = 0; k < 5; k++) begin
                logic [1:0] id;
                id = 2'(k % 4);
                cyc("t2_idle", 4'b1111, 4'b1111, 1'b0, 4'b0000, 32'h0, 1'b0, prev);
                cyc("t2_beat", 4'b1111, 4'b1111, 1'b0, 4'(1 << id), 32'hB0 + 32'(id), 1'b1, id);
                prev = id;
            end
        end
        cyc("t2_end", 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 2'd0);

        // Requester 1 long packet without last, requester 3 waiting (rr_ptr=1)
        rd[3] = 32'hD0;
        cyc("t3_idle", 4'b1010, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 2'd0);
        for (int n = 0; n < 8; n++) begin
            rd[1] = 32'hC00 + n;
            cyc("t3_burst", 4'b1010, 4'b0000, 1'b0, 4'b0010, 32'hC00 + n, 1'b1, 2'd1);
        end
        rd[1] = 32'hC08;
        cyc("t3_rel",    4'b1010, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd1);
        cyc("t3_g3",     4'b1010, 4'b1000, 1'b0, 4'b1000, 32'hD0, 1'b1, 2'd3);
        cyc("t3_idle2",  4'b0010, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd3);
        cyc("t3_resume", 4'b0010, 4'b0000, 1'b0, 4'b0010, 32'hC08, 1'b1, 2'd1);
        rd[1] = 32'hC09;
        cyc("t4_b1",     4'b0010, 4'b0000, 1'b0, 4'b0010, 32'hC09, 1'b1, 2'd1);
        // Granted requester drops valid: grant held, requester 3 not served
        rd[1] = 32'hC0A;
        cyc("t4_drop",   4'b1000, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b1, 2'd1);
        // FIFO full for 5 cycles mid-packet
        for (int n = 0; n < 5; n++)
            cyc("t4_full", 4'b0010, 4'b0000, 1'b1, 4'b0000, 32'h0, 1'b1, 2'd1);
        // Remaining 6 beats: release exactly at the 8th beat if beat_cnt held
        for (int n = 10; n < 16; n++) begin
            rd[1] = 32'hC00 + n;
            cyc("t4_after", 4'b0010, 4'b0000, 1'b0, 4'b0010, 32'hC00 + n, 1'b1, 2'd1);
        end
        cyc("t4_rel", 4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, 2'd1);

        // 16 beats from requester 0, then full with new valid
        base_cnt = wr_cnt;
        begin
            logic [1:0] prev;
            prev = 2'd1;
            for (int p = 0; p < 2; p++) begin
                cyc("t5_idle", 4'b0001, 4'b0000, 1'b0, 4'b0000, 32'h0, 1'b0, prev);
                for (int n = 0; n < 8; n++) begin
                    rd[0] = 32'hE00 + 8 * p + n;
                    cyc("t5_beat", 4'b0001, 4'b0000, 1'b0, 4'b0001, 32'hE00 + 8 * p + n, 1'b1, 2'd0);
                end
                prev = 2'd0;
            end
        end
        chk("t5_wr16", 32'(wr_cnt - base_cnt), 32'd16);
        rd[0] = 32'hEFF;
        cyc("t5_full_idle", 4'b0001, 4'b0001, 1'b1, 4'b0000, 32'h0, 1'b0, 2'd0);
        for (int n = 0; n < 4; n++)
            cyc("t5_full", 4'b0001, 4'b0001, 1'b1, 4'b0000, 32'h0, 1'b1, 2'd0);
        chk("t5_nowrite", 32'(wr_cnt - base_cnt), 32'd16);
        cyc("t5_clear", 4'b0001, 4'b0001, 1'b0, 4'b0001, 32'hEFF, 1'b1, 2'd0);
        cyc("t5_end",   4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0,   1'b0, 2'd0);

        // Reset during beat 2 of requester 3's packet (rr_ptr=1)
        rd[3] = 32'hF0;
        cyc("t6_idle", 4'b1000, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd0);
        cyc("t6_b0",   4'b1000, 4'b0000, 1'b0, 4'b1000, 32'hF0, 1'b1, 2'd3);
        rd[3] = 32'hF1;
        rst = 1'b1;
        cyc("t6_rst",  4'b1000, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b1, 2'd3);
        rst = 1'b0;
        rd[0] = 32'h55;
        cyc("t6_post", 4'b1001, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd0);
        cyc("t6_g0",   4'b1001, 4'b0001, 1'b0, 4'b0001, 32'h55, 1'b1, 2'd0);
        cyc("t6_end",  4'b0000, 4'b0000, 1'b0, 4'b0000, 32'h0,  1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
